// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD tic timer.
package bcd_timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;
   localparam bcd_t BCD_MIN = 4'd0;

   // Saturate a raw nibble into the legal BCD range.
   function automatic bcd_t bcd_clamp(input bcd_t n);
      return (n > BCD_MAX) ? BCD_MAX : n;
   endfunction

endpackage

// File: rtl/bcd_tic_timer_if.sv
// Control/status bundle between the tick-domain controller and the timer.
interface bcd_tic_timer_if #(
   parameter int unsigned DIGITS = 4
);
   localparam int unsigned DW = 4 * DIGITS;

   logic          tic;
   logic          UpDownn;
   logic          start;
   logic          stop;
   logic          clear;
   logic          load;
   logic [DW-1:0] loadVal;
   logic [DW-1:0] digits;
   logic          running;
   logic          done;
   logic          rollover;

   modport master (
      output tic, UpDownn, start, stop, clear, load, loadVal,
      input  digits, running, done, rollover
   );

   modport slave (
      input  tic, UpDownn, start, stop, clear, load, loadVal,
      output digits, running, done, rollover
   );

endinterface

// File: rtl/bcd_digit.sv
// Single BCD digit up/down step with carry/borrow in and out.
module bcd_digit
   import bcd_timer_pkg::*;
(
   input  bcd_t digit_i,
   input  logic en_i,
   input  logic up_i,
   output bcd_t digit_o,
   output logic en_o
);

   // Step the digit only when the lower digits ripple into it.
   always_comb begin
      digit_o = digit_i;
      en_o    = 1'b0;
      if (en_i) begin
         if (up_i) begin
            if (digit_i >= BCD_MAX) begin
               digit_o = BCD_MIN;
               en_o    = 1'b1;
            end else begin
               digit_o = digit_i + 4'd1;
            end
         end else begin
            if (digit_i == BCD_MIN) begin
               digit_o = BCD_MAX;
               en_o    = 1'b1;
            end else begin
               digit_o = digit_i - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/bcd_tic_timer.sv
// Tic-driven BCD stopwatch / countdown timer with run/pause control.
module bcd_tic_timer
   import bcd_timer_pkg::*;
#(
   parameter int unsigned DIGITS = 4
)(
   input  logic            boardClk,
   input  logic            rst,
   bcd_tic_timer_if.slave  bus
);

   localparam int unsigned DW = 4 * DIGITS;

   state_t        state_q,    state_d;
   logic [DW-1:0] digits_q,   digits_d;
   logic          dir_q,      dir_d;
   logic          running_q,  running_d;
   logic          done_q,     done_d;
   logic          rollover_q, rollover_d;

   logic [DW-1:0] step_digits;
   logic [DIGITS:0] en_chain;

   assign en_chain[0] = 1'b1;

   // Ripple chain producing the count one step away in the latched direction.
   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .digit_i (digits_q[4*i +: 4]),
         .en_i    (en_chain[i]),
         .up_i    (dir_q),
         .digit_o (step_digits[4*i +: 4]),
         .en_o    (en_chain[i+1])
      );
   end

   // Command priority clear > load > stop > start; tic only when no command acts.
   always_comb begin
      state_d    = state_q;
      digits_d   = digits_q;
      dir_d      = dir_q;
      done_d     = 1'b0;
      rollover_d = 1'b0;

      if (bus.clear) begin
         digits_d = '0;
         state_d  = IDLE;
      end else if (bus.load) begin
         for (int i = 0; i < DIGITS; i++) begin
            digits_d[4*i +: 4] = bcd_clamp(bus.loadVal[4*i +: 4]);
         end
         state_d = IDLE;
      end else if (bus.stop) begin
         if (state_q == RUN) begin
            state_d = PAUSE;
         end
      end else if (bus.start && (state_q != RUN)) begin
         dir_d = bus.UpDownn;
         if (!bus.UpDownn && (digits_q == '0)) begin
            state_d = EXPIRED;
            done_d  = 1'b1;
         end else begin
            state_d = RUN;
         end
      end else if (bus.tic && (state_q == RUN)) begin
         digits_d = step_digits;
         if (dir_q) begin
            rollover_d = en_chain[DIGITS];
         end else if (step_digits == '0) begin
            state_d = EXPIRED;
            done_d  = 1'b1;
         end
      end

      running_d = (state_d == RUN);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge boardClk) begin
      if (rst) begin
         state_q    <= IDLE;
         digits_q   <= '0;
         dir_q      <= 1'b1;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
         rollover_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         digits_q   <= digits_d;
         dir_q      <= dir_d;
         running_q  <= running_d;
         done_q     <= done_d;
         rollover_q <= rollover_d;
      end
   end

   assign bus.digits   = digits_q;
   assign bus.running  = running_q;
   assign bus.done     = done_q;
   assign bus.rollover = rollover_q;

endmodule

// File: tb/tb_bcd_tic_timer.sv
// Directed self-checking bench for bcd_tic_timer.
module tb_bcd_tic_timer;

   logic clk;
   logic rst;

   int unsigned n_checks;
   int unsigned n_pass;

   bcd_tic_timer_if #(.DIGITS(4)) bus ();

   bcd_tic_timer #(.DIGITS(4)) dut (
      .boardClk (clk),
      .rst      (rst),
      .bus      (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] v);
      bus.loadVal = v;
      bus.load    = 1'b1;
      cyc();
      bus.load    = 1'b0;
   endtask

   task automatic do_start(input logic up);
      bus.UpDownn = up;
      bus.start   = 1'b1;
      cyc();
      bus.start   = 1'b0;
   endtask

   initial begin
      n_checks    = 0;
      n_pass      = 0;
      rst         = 1'b1;
      bus.tic     = 1'b0;
      bus.UpDownn = 1'b0;
      bus.start   = 1'b0;
      bus.stop    = 1'b0;
      bus.clear   = 1'b0;
      bus.load    = 1'b0;
      bus.loadVal = '0;
      cyc();
      cyc();
      rst = 1'b0;
      check("rst_digits",   32'(bus.digits),   32'h0);
      check("rst_running",  32'(bus.running),  32'h0);
      check("rst_done",     32'(bus.done),     32'h0);
      check("rst_rollover", 32'(bus.rollover), 32'h0);

      // Countdown 3 -> 0
      do_load(16'h0003);
      check("dn_load", 32'(bus.digits), 32'h0003);
      check("dn_load_run", 32'(bus.running), 32'h0);
      do_start(1'b0);
      check("dn_start_run", 32'(bus.running), 32'h1);
      bus.tic = 1'b1;
      cyc();
      check("dn_t1", 32'(bus.digits), 32'h0002);
      cyc();
      check("dn_t2", 32'(bus.digits), 32'h0001);
      check("dn_t2_done", 32'(bus.done), 32'h0);
      cyc();
      check("dn_t3", 32'(bus.digits), 32'h0000);
      check("dn_t3_done", 32'(bus.done), 32'h1);
      check("dn_t3_run", 32'(bus.running), 32'h0);
      cyc();
      bus.tic = 1'b0;
      check("dn_exp_hold", 32'(bus.digits), 32'h0000);
      check("dn_done_once", 32'(bus.done), 32'h0);

      // Start down at zero: immediate expiry
      do_start(1'b0);
      check("zero_start_done", 32'(bus.done), 32'h1);
      check("zero_start_run", 32'(bus.running), 32'h0);
      check("zero_start_dig", 32'(bus.digits), 32'h0000);

      // Up rollover 9998 -> 9999 -> 0000
      do_load(16'h9998);
      do_start(1'b1);
      bus.tic = 1'b1;
      cyc();
      check("up_9999", 32'(bus.digits), 32'h9999);
      check("up_9999_roll", 32'(bus.rollover), 32'h0);
      cyc();
      bus.tic = 1'b0;
      check("up_wrap", 32'(bus.digits), 32'h0000);
      check("up_wrap_roll", 32'(bus.rollover), 32'h1);
      check("up_wrap_run", 32'(bus.running), 32'h1);
      cyc();
      check("up_roll_once", 32'(bus.rollover), 32'h0);
      check("up_still_run", 32'(bus.running), 32'h1);

      // Borrow across two digits
      do_load(16'h0100);
      do_start(1'b0);
      bus.tic = 1'b1;
      cyc();
      bus.tic = 1'b0;
      check("borrow", 32'(bus.digits), 32'h0099);
      check("borrow_run", 32'(bus.running), 32'h1);

      // Stop+tic and start+tic interactions
      do_load(16'h0005);
      do_start(1'b1);
      bus.stop = 1'b1;
      bus.tic  = 1'b1;
      cyc();
      bus.stop = 1'b0;
      bus.tic  = 1'b0;
      check("stop_tic_dig", 32'(bus.digits), 32'h0005);
      check("stop_tic_run", 32'(bus.running), 32'h0);
      bus.tic = 1'b1;
      cyc();
      check("pause_tic", 32'(bus.digits), 32'h0005);
      bus.start   = 1'b1;
      bus.UpDownn = 1'b1;
      cyc();
      bus.start = 1'b0;
      check("start_tic_dig", 32'(bus.digits), 32'h0005);
      check("start_tic_run", 32'(bus.running), 32'h1);
      bus.UpDownn = 1'b0;
      cyc();
      bus.tic = 1'b0;
      check("resume_tic", 32'(bus.digits), 32'h0006);

      // Load clamp, then clear beats load
      do_load(16'hFA37);
      check("clamp", 32'(bus.digits), 32'h9937);
      bus.clear   = 1'b1;
      bus.load    = 1'b1;
      bus.loadVal = 16'h1234;
      cyc();
      bus.clear = 1'b0;
      bus.load  = 1'b0;
      check("clr_over_load", 32'(bus.digits), 32'h0000);
      check("clr_running", 32'(bus.running), 32'h0);

      // Reset mid-count, then tics ignored without start
      do_load(16'h0040);
      do_start(1'b1);
      bus.tic = 1'b1;
      cyc();
      cyc();
      check("pre_rst", 32'(bus.digits), 32'h0042);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("mid_rst_dig", 32'(bus.digits), 32'h0000);
      check("mid_rst_run", 32'(bus.running), 32'h0);
      cyc();
      cyc();
      bus.tic = 1'b0;
      check("post_rst_dig", 32'(bus.digits), 32'h0000);
      check("post_rst_run", 32'(bus.running), 32'h0);
      check("post_rst_done", 32'(bus.done), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bcd_tic_timer.md
# bcd_tic_timer

Tic-driven BCD stopwatch/countdown timer that consumes the one-cycle `tic` strobe produced by the up/down master tick generator and turns it into human-readable time. It sits between the tick generator and the seven-segment display driver. It counts tics up or down across `DIGITS` BCD digits. Control is a small run/pause FSM with expiry and rollover strobes.

## Interface
- `DIGITS`, 4: number of BCD digits (≥1); counter range 0 … 10^DIGITS−1.
- `boardClk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `tic`  in  1  one-cycle count strobe from the tick generator.
- `UpDownn`  in  1  count direction: 1 = up, 0 = down. Sampled only on an accepted `start`.
- `start`  in  1  level; begin or resume counting.
- `stop`  in  1  level; pause counting.
- `clear`  in  1  level; zero the count and return to IDLE.
- `load`  in  1  level; load `loadVal` and return to IDLE.
- `loadVal`  in  4*DIGITS  BCD preset; digit 0 in bits [3:0].
- `digits`  out  4*DIGITS  current BCD count, registered.
- `running`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a down-count reaches zero.
- `rollover`  out  1  one-cycle pulse when an up-count wraps from all-9s to 0.

## Operation
- FSM states:
  - IDLE: reset state.
  - RUN: counting.
  - PAUSE: count held.
  - EXPIRED: down-count has reached zero; count held.
- Command priority in any state: `clear` > `load` > `stop` > `start`. Only the highest-priority asserted command acts in a cycle.
- `clear`: digits ← 0, state ← IDLE.
- `load`: each digit ← its `loadVal` nibble, with nibbles > 9 clamped to 9. State ← IDLE.
- `stop` in RUN → PAUSE. `stop` in any other state has no effect.
- `start` in IDLE, PAUSE or EXPIRED → RUN. On acceptance the direction is latched from `UpDownn`; `UpDownn` changes during RUN are ignored.
- `start` in RUN has no effect.
- `start` in down mode with count = 0 goes straight to EXPIRED and pulses `done`. No decrement occurs.
- `tic` is counted only when the state is RUN at the clock edge and no command acts in that cycle. `tic` in any other state is dropped, with no queuing.
- Up count:
  - BCD increment with ripple carry across all digits in one cycle.
  - All-9s + 1 → all-0s, `rollover` = 1, stays in RUN.
- Down count:
  - BCD decrement with ripple borrow across all digits in one cycle.
  - Reaching 0 → state EXPIRED, `done` = 1, `running` = 0.
- `digits` never holds a nibble > 9.

## Timing
- Reset values: `digits` = 0, `running` = 0, `done` = 0, `rollover` = 0, state = IDLE.
- Latency:
  - `tic` sampled at edge k → new `digits` visible after edge k.
  - `done` / `rollover` are high during the same cycle that the new value is visible, for exactly one cycle.
- `running` is registered and reflects the state after each edge.
- `start` and `tic` in the same cycle: the transition occurs but the tic is not counted. The first counted tic is the next one.
- `stop` and `tic` in the same cycle: stop wins, the count is unchanged.
- `rst` asserted mid-count: at the next edge all outputs take their reset values. Any pulse in flight is cancelled.
- Back-to-back tics (one per cycle) are each counted; no minimum spacing is required.

## Structure
- Package `bcd_timer_pkg`:
  - `state_t` enum {IDLE, RUN, PAUSE, EXPIRED}.
  - `bcd_t` (logic [3:0]).
  - constants `BCD_MAX` = 9 and `BCD_MIN` = 0.
- Sub-module `bcd_digit`:
  - Purely combinational single-digit up/down step.
  - Inputs: digit, enable-in (carry/borrow), direction.
  - Outputs: next digit, carry/borrow-out.
  - Chained `DIGITS` times in a generate loop.
  - Registers and the FSM live in the top module.

## Test plan
- Reset, then `load` 0x0003, `start` with UpDownn = 0, then 3 tics → `digits` steps 0x0002, 0x0001, 0x0000. `done` pulses once with the 0x0000 value; state EXPIRED, `running` = 0.
- `load` 0x9998, start up, then 2 tics → 0x9999, then 0x0000 with `rollover` = 1 for one cycle; `running` stays 1.
- `load` 0x0100, start down, 1 tic → 0x0099 (borrow across two digits in one cycle).
- Running up at 0x0005: `stop` together with `tic` → stays 0x0005 in PAUSE. Later `start` together with `tic` → still 0x0005. The next tic gives 0x0006.
- `load` 0xFA37 → `digits` = 0x9937. Then `clear` and `load` asserted together → `digits` = 0x0000, state IDLE.
- Mid-count at 0x0042, `rst` asserted for one cycle → `digits` = 0, all flags 0, IDLE. Tics arriving afterwards without a `start` are ignored.
